is62_bus_arbiter: RTL and testbench
===================================

Name: is62_bus_arbiter

Overview:
- Shares one external IS62 SRAM transaction channel between two requesters: port 0 (CPU-side AHB bridge) and port 1 (DMA / display fetch).
- Sits upstream of the IS62 bus sequencer.
- Accepts word/half/byte requests (24-bit byte address within the 16 MB window), grants round-robin with bounded lock, issues one start pulse per transaction, and routes completion and read data back to the owner.

Parameters:
- LOCK_MAX, 4: maximum consecutive grants to a locking port while the other port is requesting.
- TIMEOUT_CYC, 64: cycles allowed in WAIT before abort (only with the timeout macro).

Ports:
- hclk  in  1  system clock.
- hreset  in  1  synchronous active-high reset.
- m0_req  in  1  port 0 request; held until m0_gnt.
- m0_lock  in  1  port 0 requests back-to-back ownership.
- m0_addr  in  24  byte address.
- m0_write  in  1  1 = write.
- m0_size  in  3  000 = byte, 001 = half, 010 = word.
- m0_wdata  in  32  write data.
- m0_gnt  out  1  one-cycle grant pulse.
- m0_done  out  1  one-cycle completion pulse.
- m0_rdata  out  32  read data, registered.
- m0_err  out  1  timeout flag, pulses with m0_done.
- m1_*  same set as m0_*, for port 1.
- mem_start  out  1  one-cycle transaction start.
- mem_addr  out  24  latched address.
- mem_write  out  1  latched direction.
- mem_size  out  3  latched size.
- mem_wdata  out  32  latched write data.
- mem_done  in  1  downstream completion pulse.
- mem_rdata  in  32  downstream read data, valid with mem_done.
- owner  out  1  index of the current or last granted port.

Behaviour:
- Reset: state IDLE.
  - All m*_gnt, m*_done, m*_err, mem_start = 0.
  - m*_rdata = 0; mem_addr, mem_write, mem_size, mem_wdata = 0.
  - owner = 1, so port 0 wins the first tie.
  - lock_cnt = 0, timeout counter = 0.
- Reset mid-transaction abandons it immediately; the downstream sequencer shares hreset.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: pick that port.
  - Both req: pick by the selection rules below.
  - On a pick: latch addr/write/size/wdata into mem_* regs, set owner, go to ISSUE.
- Selection when both ports request:
  - If the last owner's lock = 1 and lock_cnt < LOCK_MAX: re-pick the last owner and increment lock_cnt.
  - Otherwise pick the port that is not the last owner, and set lock_cnt = 1.
  - A pick with no contention also sets lock_cnt = 1.
- ISSUE: mem_start = 1 and m<owner>_gnt = 1 for this cycle only; go to WAIT unconditionally.
- WAIT: on mem_done:
  - Read: capture mem_rdata into m<owner>_rdata.
  - Write: m<owner>_rdata is unchanged.
  - Go to DONE.
- DONE: m<owner>_done = 1 for one cycle; go to IDLE.
- mem_done outside WAIT is ignored. The downstream must not assert mem_done in the ISSUE cycle.
- Latency: req seen in IDLE at cycle 0 → start/gnt at cycle 1 → mem_done at cycle ≥ 2 → done one cycle after mem_done. Minimum 4 cycles per transaction.
- Fields are latched at the IDLE→ISSUE edge. Requester changes after that edge have no effect; dropping req after the pick still completes the transaction.
- The non-owner's gnt, done and rdata never change during another port's transaction.
- m*_rdata holds its value until the next read completion for that port.

Optional Feature:
- Macro: IS62_ARB_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC without mem_done: go to DONE, pulse m<owner>_done and m<owner>_err together, leave rdata unchanged.
  - mem_done arriving in the same cycle as the timeout wins; err = 0.
- Without the macro: WAIT is unbounded and m*_err is tied 0.

Decomposition:
- Package is62_arb_pkg:
  - State encoding (IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3).
  - Size constants SZ8 = 3'b000, SZ16 = 3'b001, SZ32 = 3'b010.
  - Port index constants P0 = 1'b0, P1 = 1'b1.
- Sub-module is62_arb_pick:
  - Combinational pick from req[1:0], lock[1:0], last owner and lock_cnt.
  - Outputs winner and the next lock_cnt value.
  - The FSM, latches and timeout stay in the top level.

Test Plan:
- Single read: after reset, m0 reads addr 0x000104 size 010, downstream returns 0xA5A5_1234 two cycles after start → mem_start and m0_gnt at cycle 1, m0_done at the cycle after mem_done, m0_rdata = 0xA5A5_1234, m1 outputs all 0.
- Tie after reset: m0 and m1 request in the same cycle, no lock → grants alternate P0, P1, P0, P1 over 4 transactions; owner toggles each time.
- Bounded lock: m1 lock = 1 with continuous req, m0 also requesting, LOCK_MAX = 4 → grants P1 ×4, then P0, then P1 resumes.
- Byte write: m1 writes size 000, addr 0x7FFFFF, wdata 0x0000_00EE → mem_addr = 0x7FFFFF, mem_size = 000, mem_write = 1, mem_wdata = 0x0000_00EE; m1_rdata unchanged; the m1 req drop after gnt is ignored.
- Reset mid-op: hreset asserted during WAIT → next cycle state IDLE, all pulses 0, owner = 1; a subsequent m0 request completes normally.
- Timeout (macro on, TIMEOUT_CYC = 64): mem_done never arrives → m0_done and m0_err pulse together after 64 WAIT cycles, then the FSM accepts m1. Macro off: the FSM stays in WAIT beyond 200 cycles with err = 0.

Source files
------------

// File: rtl/is62_arb_pkg.sv
// Shared types and constants for the IS62 two-port bus arbiter.
// The optional WAIT timeout is enabled by defining IS62_ARB_TIMEOUT_EN.
package is62_arb_pkg;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIZE_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam logic [SIZE_W-1:0] SZ8  = 3'b000;
  localparam logic [SIZE_W-1:0] SZ16 = 3'b001;
  localparam logic [SIZE_W-1:0] SZ32 = 3'b010;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  // Transaction fields latched at the pick and presented downstream.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [SIZE_W-1:0] size;
    logic [DATA_W-1:0] wdata;
  } arb_txn_t;

endpackage

// File: rtl/is62_bus_arbiter_if.sv
// Bundle of both requester ports and the downstream sequencer channel.
interface is62_bus_arbiter_if;
  import is62_arb_pkg::*;

  logic              m0_req;
  logic              m0_lock;
  logic [ADDR_W-1:0] m0_addr;
  logic              m0_write;
  logic [SIZE_W-1:0] m0_size;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_done;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_err;

  logic              m1_req;
  logic              m1_lock;
  logic [ADDR_W-1:0] m1_addr;
  logic              m1_write;
  logic [SIZE_W-1:0] m1_size;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_done;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_err;

  logic              mem_start;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_write;
  logic [SIZE_W-1:0] mem_size;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;

  logic              owner;

  // Arbiter side
  modport slave (
    input  m0_req, m0_lock, m0_addr, m0_write, m0_size, m0_wdata,
    output m0_gnt, m0_done, m0_rdata, m0_err,
    input  m1_req, m1_lock, m1_addr, m1_write, m1_size, m1_wdata,
    output m1_gnt, m1_done, m1_rdata, m1_err,
    output mem_start, mem_addr, mem_write, mem_size, mem_wdata,
    input  mem_done, mem_rdata,
    output owner
  );

  // Requester / sequencer side
  modport master (
    output m0_req, m0_lock, m0_addr, m0_write, m0_size, m0_wdata,
    input  m0_gnt, m0_done, m0_rdata, m0_err,
    output m1_req, m1_lock, m1_addr, m1_write, m1_size, m1_wdata,
    input  m1_gnt, m1_done, m1_rdata, m1_err,
    input  mem_start, mem_addr, mem_write, mem_size, mem_wdata,
    output mem_done, mem_rdata,
    input  owner
  );

endinterface

// File: rtl/is62_arb_pick.sv
// Combinational winner selection: round-robin with a bounded lock streak.
module is62_arb_pick
  import is62_arb_pkg::*;
#(
  parameter int unsigned LOCK_MAX = 4,
  parameter int unsigned CNT_W    = $clog2(LOCK_MAX + 1)
) (
  input  logic [1:0]       req,
  input  logic [1:0]       lock,
  input  logic             last_owner,
  input  logic [CNT_W-1:0] lock_cnt,
  output logic             valid_c,
  output logic             winner_c,
  output logic [CNT_W-1:0] lock_cnt_c
);

  localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_MAX);

  // Lone requester wins outright; contention keeps a locking owner until its streak hits the limit
  always_comb begin
    valid_c    = |req;
    winner_c   = last_owner;
    lock_cnt_c = lock_cnt;
    case (req)
      2'b01: begin
        winner_c   = P0;
        lock_cnt_c = CNT_W'(1);
      end
      2'b10: begin
        winner_c   = P1;
        lock_cnt_c = CNT_W'(1);
      end
      2'b11: begin
        if (lock[last_owner] && (lock_cnt < LOCK_LIM)) begin
          winner_c   = last_owner;
          lock_cnt_c = lock_cnt + CNT_W'(1);
        end else begin
          winner_c   = ~last_owner;
          lock_cnt_c = CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/is62_bus_arbiter.sv
// Two-port arbiter in front of the IS62 SRAM sequencer: picks a requester,
// issues one start per transaction and routes completion/read data back.
// Define IS62_ARB_TIMEOUT_EN to bound the WAIT state by TIMEOUT_CYC cycles.
module is62_bus_arbiter
  import is62_arb_pkg::*;
#(
  parameter int unsigned LOCK_MAX = 4
`ifdef IS62_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 64
`endif
) (
  input  logic               hclk,
  input  logic               hreset,
  is62_bus_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);
`ifdef IS62_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
`endif

  arb_state_e                  state_q, state_d;
  logic                        owner_q, owner_d;
  logic [CNT_W-1:0]            lock_cnt_q, lock_cnt_d;
  arb_txn_t                    txn_q, txn_d;
  logic                        start_q, start_d;
  logic [1:0]                  gnt_q, gnt_d;
  logic [1:0]                  done_q, done_d;
  logic [1:0][DATA_W-1:0]      rdata_q, rdata_d;
`ifdef IS62_ARB_TIMEOUT_EN
  logic [1:0]                  err_q, err_d;
  logic [TMO_W-1:0]            tmo_cnt_q, tmo_cnt_d;
`endif

  logic                        pick_valid_c;
  logic                        pick_winner_c;
  logic [CNT_W-1:0]            pick_cnt_c;

  is62_arb_pick #(
    .LOCK_MAX (LOCK_MAX),
    .CNT_W    (CNT_W)
  ) u_pick (
    .req        ({bus.m1_req, bus.m0_req}),
    .lock       ({bus.m1_lock, bus.m0_lock}),
    .last_owner (owner_q),
    .lock_cnt   (lock_cnt_q),
    .valid_c    (pick_valid_c),
    .winner_c   (pick_winner_c),
    .lock_cnt_c (pick_cnt_c)
  );

  // State register and all registered outputs
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q    <= IDLE;
      owner_q    <= P1;
      lock_cnt_q <= '0;
      txn_q      <= '0;
      start_q    <= 1'b0;
      gnt_q      <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
`ifdef IS62_ARB_TIMEOUT_EN
      err_q      <= '0;
      tmo_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      txn_q      <= txn_d;
      start_q    <= start_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
`ifdef IS62_ARB_TIMEOUT_EN
      err_q      <= err_d;
      tmo_cnt_q  <= tmo_cnt_d;
`endif
    end
  end

  // Next state; pulses are set on the edge entering ISSUE/DONE so they are high for that state only
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    txn_d      = txn_q;
    start_d    = 1'b0;
    gnt_d      = '0;
    done_d     = '0;
    rdata_d    = rdata_q;
`ifdef IS62_ARB_TIMEOUT_EN
    err_d      = '0;
    tmo_cnt_d  = tmo_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid_c) begin
          state_d             = ISSUE;
          owner_d             = pick_winner_c;
          lock_cnt_d          = pick_cnt_c;
          start_d             = 1'b1;
          gnt_d[pick_winner_c] = 1'b1;
          if (pick_winner_c == P1) begin
            txn_d.addr  = bus.m1_addr;
            txn_d.write = bus.m1_write;
            txn_d.size  = bus.m1_size;
            txn_d.wdata = bus.m1_wdata;
          end else begin
            txn_d.addr  = bus.m0_addr;
            txn_d.write = bus.m0_write;
            txn_d.size  = bus.m0_size;
            txn_d.wdata = bus.m0_wdata;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef IS62_ARB_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      WAIT: begin
        if (bus.mem_done) begin
          state_d         = DONE;
          done_d[owner_q] = 1'b1;
          if (!txn_q.write) begin
            rdata_d[owner_q] = bus.mem_rdata;
          end
        end
`ifdef IS62_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          state_d         = DONE;
          done_d[owner_q] = 1'b1;
          err_d[owner_q]  = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
`endif
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_start = start_q;
  assign bus.mem_addr  = txn_q.addr;
  assign bus.mem_write = txn_q.write;
  assign bus.mem_size  = txn_q.size;
  assign bus.mem_wdata = txn_q.wdata;
  assign bus.owner     = owner_q;
  assign bus.m0_gnt    = gnt_q[P0];
  assign bus.m1_gnt    = gnt_q[P1];
  assign bus.m0_done   = done_q[P0];
  assign bus.m1_done   = done_q[P1];
  assign bus.m0_rdata  = rdata_q[P0];
  assign bus.m1_rdata  = rdata_q[P1];
`ifdef IS62_ARB_TIMEOUT_EN
  assign bus.m0_err    = err_q[P0];
  assign bus.m1_err    = err_q[P1];
`else
  assign bus.m0_err    = 1'b0;
  assign bus.m1_err    = 1'b0;
`endif

endmodule

// File: tb/tb_is62_bus_arbiter.sv
// Bench for is62_bus_arbiter: transaction-timeline model checked every cycle
// plus directed scenarios with literal expectations.
module tb_is62_bus_arbiter;
  import is62_arb_pkg::*;

  localparam int unsigned LOCK_MAX    = 4;
  localparam int unsigned TIMEOUT_CYC = 64;

  logic hclk = 1'b0;
  logic hreset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  is62_bus_arbiter_if bus();

`ifdef IS62_ARB_TIMEOUT_EN
  is62_bus_arbiter #(.LOCK_MAX(LOCK_MAX), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .hclk(hclk), .hreset(hreset), .bus(bus));
`else
  is62_bus_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .hclk(hclk), .hreset(hreset), .bus(bus));
`endif

  always #5 hclk = ~hclk;
  always @(posedge hclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Requesters: hold req while issued transactions exceed grants seen
  int issue_cnt[2];
  int gnt_cnt[2];
  always @(posedge hclk) begin
    #2;
    if (bus.m0_gnt === 1'b1) gnt_cnt[0]++;
    if (bus.m1_gnt === 1'b1) gnt_cnt[1]++;
    bus.m0_req = (issue_cnt[0] != gnt_cnt[0]);
    bus.m1_req = (issue_cnt[1] != gnt_cnt[1]);
  end

  // Downstream sequencer: mem_done resp_lat cycles after mem_start
  int          resp_lat = 2;
  bit          resp_en = 1'b1;
  logic [31:0] resp_data = 32'h0;
  int          pend = 0;
  always @(posedge hclk) begin
    #1;
    bus.mem_done = 1'b0;
    if (hreset) pend = 0;
    else if (bus.mem_start === 1'b1) pend = resp_lat;
    else if (pend > 0) begin
      pend--;
      if (pend == 0 && resp_en) bus.mem_done = 1'b1;
    end
    bus.mem_rdata = resp_data;
  end

  // Model: one transaction at a time, described by the cycles its pulses are due
  bit          mv = 1'b0;
  bit          m_busy;
  logic        m_owner;
  int          m_lockcnt;
  int          m_start_due = -1;
  int          m_done_due = -1;
  logic [23:0] m_addr;
  logic        m_write;
  logic [2:0]  m_size;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata[2];
  bit          m_rd_pend;
  logic [31:0] m_rd_val;
  bit          m_err_pend;

  int gnt_log[$];
  int gnt_cyc[2];
  int done_cyc[2];
  int done_n[2];
  bit err_seen[2];

  always @(negedge hclk) begin
    logic [1:0] rq, lk, eg, ed, ee;
    if (bus.m0_gnt === 1'b1) begin gnt_log.push_back(0); gnt_cyc[0] = cyc; end
    if (bus.m1_gnt === 1'b1) begin gnt_log.push_back(1); gnt_cyc[1] = cyc; end
    if (bus.m0_done === 1'b1) begin done_n[0]++; done_cyc[0] = cyc; err_seen[0] = bus.m0_err; end
    if (bus.m1_done === 1'b1) begin done_n[1]++; done_cyc[1] = cyc; err_seen[1] = bus.m1_err; end

    if (mv) begin
      if (cyc == m_done_due && m_rd_pend) begin
        m_rdata[m_owner] = m_rd_val;
        m_rd_pend = 1'b0;
      end
      eg = '0; ed = '0; ee = '0;
      if (cyc == m_start_due) eg[m_owner] = 1'b1;
      if (cyc == m_done_due) begin ed[m_owner] = 1'b1; ee[m_owner] = m_err_pend; end
      check("mem_start", bus.mem_start, cyc == m_start_due);
      check("m0_gnt", bus.m0_gnt, eg[0]);
      check("m1_gnt", bus.m1_gnt, eg[1]);
      check("m0_done", bus.m0_done, ed[0]);
      check("m1_done", bus.m1_done, ed[1]);
      check("m0_err", bus.m0_err, ee[0]);
      check("m1_err", bus.m1_err, ee[1]);
      check("m0_rdata", bus.m0_rdata, m_rdata[0]);
      check("m1_rdata", bus.m1_rdata, m_rdata[1]);
      check("owner", bus.owner, m_owner);
      check("mem_addr", bus.mem_addr, m_addr);
      check("mem_write", bus.mem_write, m_write);
      check("mem_size", bus.mem_size, m_size);
      check("mem_wdata", bus.mem_wdata, m_wdata);
    end

    rq = {bus.m1_req, bus.m0_req};
    lk = {bus.m1_lock, bus.m0_lock};
    if (hreset) begin
      mv = 1'b1; m_busy = 1'b0; m_owner = 1'b1; m_lockcnt = 0;
      m_start_due = -1; m_done_due = -1;
      m_addr = '0; m_write = 1'b0; m_size = '0; m_wdata = '0;
      m_rdata[0] = '0; m_rdata[1] = '0; m_rd_pend = 1'b0; m_err_pend = 1'b0;
    end else if (mv) begin
      if (m_busy && cyc == m_done_due) begin
        m_busy = 1'b0;
        m_done_due = -1;
      end else if (!m_busy && rq != 2'b00) begin
        m_busy = 1'b1;
        m_start_due = cyc + 1;
        if (rq == 2'b11) begin
          if (lk[m_owner] && m_lockcnt < int'(LOCK_MAX)) m_lockcnt++;
          else begin m_owner = ~m_owner; m_lockcnt = 1; end
        end else begin
          m_owner = rq[1];
          m_lockcnt = 1;
        end
        m_addr  = m_owner ? bus.m1_addr  : bus.m0_addr;
        m_write = m_owner ? bus.m1_write : bus.m0_write;
        m_size  = m_owner ? bus.m1_size  : bus.m0_size;
        m_wdata = m_owner ? bus.m1_wdata : bus.m0_wdata;
      end else if (m_busy && cyc > m_start_due && m_done_due < 0) begin
        if (bus.mem_done === 1'b1) begin
          m_done_due = cyc + 1;
          m_err_pend = 1'b0;
          if (!m_write) begin m_rd_pend = 1'b1; m_rd_val = bus.mem_rdata; end
        end
`ifdef IS62_ARB_TIMEOUT_EN
        else if (cyc - (m_start_due + 1) == int'(TIMEOUT_CYC) - 1) begin
          m_done_due = cyc + 1;
          m_err_pend = 1'b1;
        end
`endif
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge hclk);
    #1;
  endtask

  task automatic do_reset(input int n);
    hreset = 1'b1;
    tick(n);
    hreset = 1'b0;
  endtask

  task automatic wait_done(input int p, input int target, input int budget, input string name);
    int t = 0;
    while (done_n[p] < target && t < budget) begin
      tick(1);
      t++;
    end
    check(name, done_n[p] >= target, 1'b1);
  endtask

  task automatic check_order(input string name, input int exp_q[$]);
    check({name, "_len"}, gnt_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < gnt_log.size(); i++)
      check(name, gnt_log[i], exp_q[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, b0, b1;
    bus.m0_lock = 1'b0; bus.m0_addr = '0; bus.m0_write = 1'b0; bus.m0_size = SZ16; bus.m0_wdata = '0;
    bus.m1_lock = 1'b0; bus.m1_addr = '0; bus.m1_write = 1'b0; bus.m1_size = SZ16; bus.m1_wdata = '0;

    // Reset values
    tick(1);
    do_reset(3);
    check("rst_owner", bus.owner, 1'b1);
    check("rst_m0_rdata", bus.m0_rdata, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 24'h0);
    check("rst_mem_start", bus.mem_start, 1'b0);

    // Single read from port 0
    bus.m0_addr = 24'h000104; bus.m0_size = SZ32; bus.m0_write = 1'b0;
    resp_lat = 2; resp_data = 32'hA5A5_1234;
    b0 = done_n[0];
    issue_cnt[0]++;
    c0 = cyc;
    wait_done(0, b0 + 1, 40, "single_done");
    check("single_gnt_cycle", gnt_cyc[0], c0 + 1);
    check("single_done_cycle", done_cyc[0], c0 + 4);
    check("single_rdata", bus.m0_rdata, 32'hA5A5_1234);
    check("single_m1_done", done_n[1], 0);
    check("single_m1_rdata", bus.m1_rdata, 32'h0);
    tick(2);

    // Tie after reset: strict alternation starting with port 0
    do_reset(2);
    gnt_log.delete();
    resp_data = 32'h1111_0000;
    b0 = done_n[0]; b1 = done_n[1];
    issue_cnt[0] += 2; issue_cnt[1] += 2;
    wait_done(0, b0 + 2, 80, "tie_done0");
    wait_done(1, b1 + 2, 80, "tie_done1");
    check_order("tie_order", '{0, 1, 0, 1});
    tick(2);

    // Bounded lock: port 1 keeps the bus LOCK_MAX times, then yields once
    do_reset(2);
    gnt_log.delete();
    resp_data = 32'h3333_0003;
    bus.m1_lock = 1'b1;
    b0 = done_n[0]; b1 = done_n[1];
    issue_cnt[1] += 5; issue_cnt[0] += 1;
    wait_done(1, b1 + 5, 120, "lock_done1");
    wait_done(0, b0 + 1, 120, "lock_done0");
    check_order("lock_order", '{1, 1, 1, 1, 0, 1});
    bus.m1_lock = 1'b0;
    tick(2);

    // Byte write from port 1; late field changes must not leak downstream
    bus.m1_write = 1'b1; bus.m1_size = SZ8; bus.m1_addr = 24'h7FFFFF; bus.m1_wdata = 32'h0000_00EE;
    resp_data = 32'hDEAD_BEEF;
    b1 = done_n[1];
    issue_cnt[1]++;
    tick(2);
    bus.m1_addr = 24'h123456; bus.m1_wdata = 32'h5555_5555;
    wait_done(1, b1 + 1, 40, "write_done");
    check("write_mem_addr", bus.mem_addr, 24'h7FFFFF);
    check("write_mem_size", bus.mem_size, 3'b000);
    check("write_mem_write", bus.mem_write, 1'b1);
    check("write_mem_wdata", bus.mem_wdata, 32'h0000_00EE);
    check("write_m1_rdata", bus.m1_rdata, 32'h3333_0003);
    bus.m1_write = 1'b0;
    tick(2);

    // Reset in WAIT abandons the transaction; the next request completes
    resp_en = 1'b0;
    resp_data = 32'h0BAD_0BAD;
    issue_cnt[0]++;
    tick(4);
    hreset = 1'b1;
    tick(1);
    hreset = 1'b0;
    check("midrst_owner", bus.owner, 1'b1);
    check("midrst_start", bus.mem_start, 1'b0);
    check("midrst_m0_done", bus.m0_done, 1'b0);
    check("midrst_m0_rdata", bus.m0_rdata, 32'h0);
    check("midrst_mem_addr", bus.mem_addr, 24'h0);
    resp_en = 1'b1;
    resp_data = 32'hC0DE_0042;
    b0 = done_n[0];
    issue_cnt[0]++;
    wait_done(0, b0 + 1, 40, "midrst_after_done");
    check("midrst_after_rdata", bus.m0_rdata, 32'hC0DE_0042);
    tick(2);

`ifdef IS62_ARB_TIMEOUT_EN
    // Timeout: done and err together after TIMEOUT_CYC WAIT cycles, then port 1 is served
    resp_en = 1'b0;
    b0 = done_n[0];
    issue_cnt[0]++;
    wait_done(0, b0 + 1, 150, "tmo_done");
    check("tmo_latency", done_cyc[0] - gnt_cyc[0], 65);
    check("tmo_err", err_seen[0], 1'b1);
    check("tmo_rdata_kept", bus.m0_rdata, 32'hC0DE_0042);
    resp_en = 1'b1;
    resp_data = 32'h7777_0001;
    b1 = done_n[1];
    issue_cnt[1]++;
    wait_done(1, b1 + 1, 40, "tmo_next_done");
    check("tmo_next_err", err_seen[1], 1'b0);
`else
    // No timeout: WAIT holds indefinitely with err low
    resp_en = 1'b0;
    b0 = done_n[0];
    issue_cnt[0]++;
    tick(210);
    check("notmo_no_done", done_n[0], b0);
    check("notmo_err", bus.m0_err, 1'b0);
    do_reset(2);
    resp_en = 1'b1;
`endif
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
